// File: rtl/cook_pkg.sv
// Shared definitions for the microwave cook sequencer: state encoding and timing constants.
package cook_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COOK  = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } cook_state_e;

    localparam int BEEP_TICKS = 3;
    localparam int WIN_LEN    = 10;
    localparam int PWR_MAX    = 10;

endpackage

// File: rtl/duty_window.sv
// Power duty-cycle window: a 10-second window counter, latched power level and the magnetron compare.
module duty_window
    import cook_pkg::*;
(
    input  logic       clk,
    input  logic       clear,
    input  logic       cooking,
    input  logic       load_fresh,
    input  logic       load_resume,
    input  logic       sec_tick,
    input  logic       door_closed,
    input  logic [3:0] power_lvl,
    output logic       mag_on
);

    logic [3:0] win_q;
    logic [3:0] pwr_q;

    function automatic logic [3:0] sat_pwr(input logic [3:0] lvl);
        return (lvl > 4'(PWR_MAX)) ? 4'(PWR_MAX) : lvl;
    endfunction

    always_ff @(posedge clk) begin
        if (clear) begin
            win_q <= 4'd0;
            pwr_q <= 4'd0;
        end else begin
            if (load_fresh || load_resume)
                pwr_q <= sat_pwr(power_lvl);
            // A fresh cook restarts the window; a resume keeps where the pause left it.
            if (load_fresh)
                win_q <= 4'd0;
            else if (cooking && sec_tick)
                win_q <= (win_q == 4'(WIN_LEN - 1)) ? 4'd0 : win_q + 4'd1;
        end
    end

    // Door term is deliberately combinational so an opening door cuts the magnetron at once.
    assign mag_on = cooking && (win_q < pwr_q) && door_closed;

endmodule

// File: rtl/cook_sequencer.sv
// Microwave cook sequencer FSM (IDLE/COOK/PAUSE/DONE) driving timer control, magnetron and buzzer.
// Define COOK_BEEP_EN to drive done_beep during DONE; otherwise done_beep is tied low.
module cook_sequencer
    import cook_pkg::*;
(
    input  logic       clk,
    input  logic       clear,
    input  logic       start_req,
    input  logic       stop_req,
    input  logic       door_closed,
    input  logic [3:0] power_lvl,
    input  logic       sec_tick,
    input  logic       time_zero,
    output logic       timer_en,
    output logic       timer_clr,
    output logic       mag_on,
    output logic       done_beep,
    output logic [1:0] state
);

    cook_state_e state_q;
    logic [1:0]  beep_cnt_q;
    logic        timer_clr_q;
    logic        go_fresh;
    logic        go_resume;

    // stop_req outranks start_req in every state, so both entries into COOK mask it out.
    assign go_fresh  = (state_q == IDLE) && start_req && !stop_req && door_closed && !time_zero;
    assign go_resume = (state_q == PAUSE) && start_req && !stop_req && door_closed;

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q     <= IDLE;
            beep_cnt_q  <= 2'd0;
            timer_clr_q <= 1'b0;
        end else begin
            timer_clr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (stop_req)
                        timer_clr_q <= 1'b1;
                    else if (go_fresh)
                        state_q <= COOK;
                end
                COOK: begin
                    if (time_zero) begin
                        state_q    <= DONE;
                        beep_cnt_q <= 2'd0;
                    end else if (stop_req || !door_closed) begin
                        state_q <= PAUSE;
                    end
                end
                PAUSE: begin
                    if (stop_req) begin
                        state_q     <= IDLE;
                        timer_clr_q <= 1'b1;
                    end else if (go_resume) begin
                        state_q <= COOK;
                    end
                end
                DONE: begin
                    if (stop_req) begin
                        state_q    <= IDLE;
                        beep_cnt_q <= 2'd0;
                    end else if (sec_tick) begin
                        if (beep_cnt_q == 2'(BEEP_TICKS - 1)) begin
                            state_q    <= IDLE;
                            beep_cnt_q <= 2'd0;
                        end else begin
                            beep_cnt_q <= beep_cnt_q + 2'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    duty_window u_duty_window (
        .clk         (clk),
        .clear       (clear),
        .cooking     (state_q == COOK),
        .load_fresh  (go_fresh),
        .load_resume (go_resume),
        .sec_tick    (sec_tick),
        .door_closed (door_closed),
        .power_lvl   (power_lvl),
        .mag_on      (mag_on)
    );

    assign state     = state_q;
    assign timer_en  = (state_q == COOK);
    assign timer_clr = timer_clr_q;

`ifdef COOK_BEEP_EN
    assign done_beep = (state_q == DONE);
`else
    assign done_beep = 1'b0;
`endif

endmodule

// File: tb/tb_cook_sequencer.sv
// Directed scoreboard bench for cook_sequencer: expectations are queued as stimulus is driven.
module tb_cook_sequencer;

    logic       clk = 1'b0;
    logic       clear = 1'b0;
    logic       start_req = 1'b0;
    logic       stop_req = 1'b0;
    logic       door_closed = 1'b0;
    logic [3:0] power_lvl = 4'd0;
    logic       sec_tick = 1'b0;
    logic       time_zero = 1'b0;
    logic       timer_en;
    logic       timer_clr;
    logic       mag_on;
    logic       done_beep;
    logic [1:0] state;

`ifdef COOK_BEEP_EN
    localparam bit BEEP_EN = 1'b1;
`else
    localparam bit BEEP_EN = 1'b0;
`endif

    localparam logic [1:0] S_IDLE = 2'd0, S_COOK = 2'd1, S_PAUSE = 2'd2, S_DONE = 2'd3;

    typedef struct {
        string      tag;
        logic [1:0] st;
        logic       ten;
        logic       tclr;
        logic       mag;
        logic       beep;
    } exp_t;

    exp_t q[$];
    int   n_assert = 0;
    int   n_fail = 0;

    cook_sequencer dut (
        .clk         (clk),
        .clear       (clear),
        .start_req   (start_req),
        .stop_req    (stop_req),
        .door_closed (door_closed),
        .power_lvl   (power_lvl),
        .sec_tick    (sec_tick),
        .time_zero   (time_zero),
        .timer_en    (timer_en),
        .timer_clr   (timer_clr),
        .mag_on      (mag_on),
        .done_beep   (done_beep),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [1:0] st, input logic tclr, input logic mag);
        exp_t e;
        e.tag  = tag;
        e.st   = st;
        e.ten  = (st == S_COOK);
        e.tclr = tclr;
        e.mag  = mag;
        e.beep = BEEP_EN && (st == S_DONE);
        q.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        if (q.size() == 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = q.pop_front();
        cmp({e.tag, ".state"},     {2'b00, state},     {2'b00, e.st});
        cmp({e.tag, ".timer_en"},  {3'b000, timer_en},  {3'b000, e.ten});
        cmp({e.tag, ".timer_clr"}, {3'b000, timer_clr}, {3'b000, e.tclr});
        cmp({e.tag, ".mag_on"},    {3'b000, mag_on},    {3'b000, e.mag});
        cmp({e.tag, ".done_beep"}, {3'b000, done_beep}, {3'b000, e.beep});
    endtask

    // One clock: drive pulses before the edge, queue the post-edge expectation, check after the edge.
    task automatic cyc(input string tag, input logic s, input logic p, input logic t,
                       input logic [1:0] st, input logic tclr, input logic mag);
        @(negedge clk);
        start_req = s;
        stop_req  = p;
        sec_tick  = t;
        push(tag, st, tclr, mag);
        @(posedge clk);
        #1;
        start_req = 1'b0;
        stop_req  = 1'b0;
        sec_tick  = 1'b0;
        check_pop();
    endtask

    // Check combinational response to a level input change without a clock edge.
    task automatic chk_now(input string tag, input logic [1:0] st, input logic mag);
        #1;
        push(tag, st, 1'b0, mag);
        check_pop();
    endtask

    initial begin
        int w;

        clear = 1'b1;
        cyc("reset", 0, 0, 0, S_IDLE, 0, 0);
        clear = 1'b0;

        power_lvl = 4'd10; door_closed = 1'b0;
        cyc("start_door_open", 1, 0, 0, S_IDLE, 0, 0);
        cyc("idle_hold", 0, 0, 0, S_IDLE, 0, 0);
        cyc("idle_stop", 0, 1, 0, S_IDLE, 1, 0);
        cyc("idle_clr_end", 0, 0, 0, S_IDLE, 0, 0);
        door_closed = 1'b1; time_zero = 1'b1;
        cyc("start_time_zero", 1, 0, 0, S_IDLE, 0, 0);
        time_zero = 1'b0;
        cyc("idle_start_stop", 1, 1, 0, S_IDLE, 1, 0);

        power_lvl = 4'd3;
        cyc("start_p3", 1, 0, 0, S_COOK, 0, 1);
        w = 0;
        for (int i = 0; i < 23; i++) begin
            w = (w + 1) % 10;
            cyc($sformatf("p3_tick%0d", i), 0, 0, 1, S_COOK, 0, w < 3);
        end
        cyc("p3_no_tick", 0, 0, 0, S_COOK, 0, 0);

        door_closed = 1'b0;
        chk_now("door_kill", S_COOK, 0);
        cyc("door_pause", 0, 0, 0, S_PAUSE, 0, 0);
        cyc("pause_tick", 0, 0, 1, S_PAUSE, 0, 0);
        cyc("pause_start_door_open", 1, 0, 0, S_PAUSE, 0, 0);
        door_closed = 1'b1;
        chk_now("door_reclosed", S_PAUSE, 0);
        cyc("resume", 1, 0, 0, S_COOK, 0, 0);
        for (int i = 0; i < 8; i++) begin
            w = (w + 1) % 10;
            cyc($sformatf("resume_tick%0d", i), 0, 0, 1, S_COOK, 0, w < 3);
        end
        cyc("cook_stop", 0, 1, 0, S_PAUSE, 0, 0);
        cyc("pause_start_stop", 1, 1, 0, S_IDLE, 1, 0);
        cyc("pause_clr_end", 0, 0, 0, S_IDLE, 0, 0);

        power_lvl = 4'd1;
        cyc("fresh_win_reset", 1, 0, 0, S_COOK, 0, 1);
        time_zero = 1'b1;
        cyc("tz_and_stop", 0, 1, 0, S_DONE, 0, 0);
        time_zero = 1'b0;
        cyc("done_start", 1, 0, 0, S_DONE, 0, 0);
        cyc("done_beep1", 0, 0, 1, S_DONE, 0, 0);
        cyc("done_idle_cycle", 0, 0, 0, S_DONE, 0, 0);
        cyc("done_beep2", 0, 0, 1, S_DONE, 0, 0);
        cyc("done_beep3", 0, 0, 1, S_IDLE, 0, 0);

        cyc("start_again", 1, 0, 0, S_COOK, 0, 1);
        time_zero = 1'b1;
        cyc("tz_done", 0, 0, 0, S_DONE, 0, 0);
        time_zero = 1'b0;
        cyc("done_stop", 0, 1, 0, S_IDLE, 0, 0);

        power_lvl = 4'd0;
        cyc("start_p0", 1, 0, 0, S_COOK, 0, 0);
        for (int i = 0; i < 10; i++)
            cyc($sformatf("p0_tick%0d", i), 0, 0, 1, S_COOK, 0, 0);
        cyc("p0_stop", 0, 1, 0, S_PAUSE, 0, 0);
        power_lvl = 4'd15;
        cyc("resume_p15", 1, 0, 0, S_COOK, 0, 1);
        for (int i = 0; i < 12; i++)
            cyc($sformatf("p15_tick%0d", i), 0, 0, 1, S_COOK, 0, 1);

        clear = 1'b1;
        cyc("clear_mid_cook", 0, 0, 0, S_IDLE, 0, 0);
        clear = 1'b0;
        cyc("after_clear", 0, 0, 0, S_IDLE, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cook_sequencer.md
COOK_SEQUENCER -- requirements
Module: cook_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port clear, input, 1 bit: synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port start_req, input, 1 bit: start request, one-cycle pulse from the keypad front end.
REQ-004 SHALL have port stop_req, input, 1 bit: stop/cancel request, one-cycle pulse.
REQ-005 SHALL have port door_closed, input, 1 bit: 1 = door closed.
REQ-006 SHALL have port power_lvl, input, 4 bits: requested power level 0..10; values above 10 saturate to 10.
REQ-007 SHALL have port sec_tick, input, 1 bit: one-cycle pulse once per second from the countdown timer.
REQ-008 SHALL have port time_zero, input, 1 bit: countdown timer reads 00:00.
REQ-009 SHALL have port timer_en, output, 1 bit: enables countdown in the timer datapath.
REQ-010 SHALL have port timer_clr, output, 1 bit: one-cycle pulse that clears the timer digits.
REQ-011 SHALL have port mag_on, output, 1 bit: magnetron drive.
REQ-012 SHALL have port done_beep, output, 1 bit: end-of-cook buzzer.
REQ-013 SHALL have port state, output, 2 bits: current FSM state encoding.

Function
REQ-014 SHALL implement FSM states IDLE=0, COOK=1, PAUSE=2, DONE=3.
REQ-015 IDLE->COOK SHALL occur on start_req & door_closed & !time_zero; start_req with the door open or time_zero=1 SHALL be ignored.
REQ-016 In COOK, priority SHALL be time_zero (->DONE) > stop_req or !door_closed (->PAUSE).
REQ-017 PAUSE->COOK SHALL occur on start_req & door_closed; PAUSE->IDLE SHALL occur on stop_req and pulse timer_clr for 1 cycle.
REQ-018 When start_req and stop_req are asserted in the same cycle, stop_req SHALL win in every state.
REQ-019 IDLE with stop_req SHALL pulse timer_clr and stay in IDLE.
REQ-020 DONE SHALL return to IDLE after BEEP_TICKS (=3) sec_ticks, or immediately on stop_req; start_req SHALL be ignored in DONE.
REQ-021 The state register SHALL update on the clk edge after inputs are sampled (1-cycle latency); outputs SHALL be decoded from the registered state.
REQ-022 timer_en SHALL equal (state==COOK).
REQ-023 power_lvl SHALL be saturated and latched into pwr_q on each IDLE->COOK and PAUSE->COOK transition; pwr_q SHALL be held otherwise.
REQ-024 The duty window counter win (0..9) SHALL increment on sec_tick in COOK, wrap 9->0, reset to 0 on IDLE->COOK, and hold in PAUSE.
REQ-025 mag_on SHALL equal (state==COOK) & (win < pwr_q) & door_closed; the door_closed term SHALL be combinational, so an open door kills mag_on in the same cycle.
REQ-026 With pwr_q=0, mag_on SHALL never assert; with pwr_q=10, mag_on SHALL be continuous in COOK.

Reset
REQ-027 On clear=1 at a clk edge, outputs SHALL reset to state=IDLE, win=0, pwr_q=0, timer_en=0, mag_on=0, done_beep=0, timer_clr=0, beep count=0.
REQ-028 clear asserted mid-COOK SHALL drop mag_on and timer_en on the next edge; clear SHALL NOT pulse timer_clr.

Configuration
REQ-029 Macro COOK_BEEP_EN: when defined, done_beep SHALL equal (state==DONE).
REQ-030 When COOK_BEEP_EN is undefined, done_beep SHALL be tied to 0 and DONE SHALL still last BEEP_TICKS sec_ticks.

Structure
REQ-031 A shared package cook_pkg SHALL hold the state encoding, BEEP_TICKS=3, WIN_LEN=10 and PWR_MAX=10.
REQ-032 Sub-module duty_window SHALL contain the win counter, pwr_q, and the mag_on compare; the FSM SHALL reside in cook_sequencer.

Verification
REQ-033 Scenario: clear, power_lvl=10, door_closed=0, start_req -> state stays IDLE, mag_on=0.
REQ-034 Scenario: door_closed=1, power_lvl=3, start_req, then 20 sec_ticks with time_zero=0 -> mag_on high for exactly ticks 0-2 and 10-12 of each window (6 s total), timer_en=1 throughout.
REQ-035 Scenario: in COOK, drop door_closed -> mag_on=0 in the same cycle, state=PAUSE next cycle, win held; close the door and start_req -> COOK resumes with win unchanged.
REQ-036 Scenario: in PAUSE, start_req and stop_req in the same cycle -> IDLE, one-cycle timer_clr.
REQ-037 Scenario: in COOK, time_zero=1 together with stop_req -> DONE; with COOK_BEEP_EN defined, done_beep=1 for 3 sec_ticks, then IDLE.
REQ-038 Scenario: power_lvl=15 -> behaves as 10 (mag_on continuous); clear mid-COOK -> all outputs 0 on the next edge.
